// File: rtl/calc_sequencer.sv
// Enter-driven operand/operator sequencer with signed add/sub/max/min core.
// A and B are collected on Enter edges and the result is computed in EXEC; results can be chained.
module calc_sequencer #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enter,
    input  logic [WIDTH-1:0] Operand,
    input  logic             OperandValid,
    input  logic [1:0]       Op,
    input  logic             Chain,
    output logic [WIDTH-1:0] Display,
    output logic [WIDTH-1:0] Result,
    output logic             OVR,
    output logic             Err,
    output logic             ShowResult,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] OpCount
);

    // state  | meaning
    // IDLE   | waiting for first Enter
    // GET_A  | Display shows live Operand; Enter latches A
    // GET_B  | Display shows live Operand; Enter latches B and Op
    // EXEC   | one-cycle compute, Result/OVR/OpCount registered
    // SHOW   | Display holds Result; Enter chains or restarts
    // ERROR  | invalid operand entered; Enter restarts at GET_A
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_SHOW  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               enter_q;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               ev;
    logic [WIDTH:0]     a_ext, b_ext, sum;
    logic               sum_ovf;
    logic               a_gt_b;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    assign ev = Enter & ~enter_q;

    always_comb begin
        a_ext   = {a_q[WIDTH-1], a_q};
        b_ext   = {b_q[WIDTH-1], b_q};
        sum     = op_q[0] ? (a_ext - b_ext) : (a_ext + b_ext);
        // With one guard bit, disagreement between the top two bits is exactly signed overflow.
        sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        a_gt_b  = $signed(a_q) > $signed(b_q);
        alu_res = sum[WIDTH-1:0];
        alu_ovf = 1'b0;
        case (op_q)
            2'b10: alu_res = a_gt_b ? a_q : b_q;
            2'b11: alu_res = a_gt_b ? b_q : a_q;
            default: begin
                alu_ovf = sum_ovf;
                if (SATURATE && sum_ovf) begin
                    alu_res = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        ovr_d    = ovr_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ev) state_d = S_GET_A;
            end
            S_GET_A, S_GET_B: begin
                if (ev) begin
                    if (!OperandValid) begin
                        state_d  = S_ERROR;
                        a_d      = '0;
                        b_d      = '0;
                        result_d = '0;
                        cnt_d    = '0;
                    end else if (state_q == S_GET_A) begin
                        a_d     = Operand;
                        state_d = S_GET_B;
                    end else begin
                        b_d     = Operand;
                        op_d    = Op;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                result_d = alu_res;
                ovr_d    = alu_ovf;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (ev) begin
                    if (Chain) begin
                        a_d     = result_q;
                        state_d = S_GET_B;
                    end else begin
                        cnt_d   = '0;
                        ovr_d   = 1'b0;
                        state_d = S_GET_A;
                    end
                end
            end
            S_ERROR: begin
                if (ev) state_d = S_GET_A;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            enter_q  <= 1'b1;   // a button held through reset must not fire
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            enter_q  <= Enter;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        Display    = '0;
        ShowResult = 1'b0;
        case (state_q)
            S_GET_A, S_GET_B: Display = Operand;
            S_EXEC, S_SHOW: begin
                Display    = result_q;
                ShowResult = 1'b1;
            end
            default: Display = '0;
        endcase
    end

    assign Result  = result_q;
    assign OVR     = ovr_q;
    assign Err     = (state_q == S_ERROR);
    assign State   = state_q;
    assign OpCount = cnt_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a saturating and a wrapping instance share one stimulus.
module tb_calc_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Enter = 1'b1;
    logic [7:0] Operand = 8'd0;
    logic       OperandValid = 1'b0;
    logic [1:0] Op = 2'b00;
    logic       Chain = 1'b0;

    logic [7:0] disp_s, res_s, disp_w, res_w;
    logic       ovr_s, err_s, show_s, ovr_w, err_w, show_w;
    logic [2:0] st_s, st_w;
    logic [3:0] cnt_s, cnt_w;

    int checks = 0;
    int failures = 0;

    calc_sequencer #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(4)) dut_s (
        .Clock(Clock), .Reset(Reset), .Enter(Enter), .Operand(Operand),
        .OperandValid(OperandValid), .Op(Op), .Chain(Chain),
        .Display(disp_s), .Result(res_s), .OVR(ovr_s), .Err(err_s),
        .ShowResult(show_s), .State(st_s), .OpCount(cnt_s)
    );

    calc_sequencer #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(4)) dut_w (
        .Clock(Clock), .Reset(Reset), .Enter(Enter), .Operand(Operand),
        .OperandValid(OperandValid), .Op(Op), .Chain(Chain),
        .Display(disp_w), .Result(res_w), .OVR(ovr_w), .Err(err_w),
        .ShowResult(show_w), .State(st_w), .OpCount(cnt_w)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic press();
        Enter = 1'b1;
        tick();
        Enter = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with Enter held high
        tick();
        tick();
        chk("rst_state", 32'(st_s), 32'd0);
        chk("rst_display", 32'(disp_s), 32'd0);
        chk("rst_result", 32'(res_s), 32'd0);
        chk("rst_ovr", 32'(ovr_s), 32'd0);
        chk("rst_cnt", 32'(cnt_s), 32'd0);
        chk("rst_err_show", 32'({err_s, show_s}), 32'd0);
        Reset = 1'b0;
        tick(); tick(); tick();
        chk("held_through_reset", 32'(st_s), 32'd0);
        Enter = 1'b0;
        tick();

        // held Enter gives one transition; a retrigger would hit ERROR (OperandValid=0)
        Enter = 1'b1;
        repeat (20) tick();
        chk("hold_one_transition", 32'(st_s), 32'd1);
        Enter = 1'b0;
        tick();

        // 100 + 50
        Operand = 8'd100; OperandValid = 1'b1;
        #1;
        chk("display_live_a", 32'(disp_s), 32'd100);
        press();
        chk("get_b_state", 32'(st_s), 32'd2);
        Operand = 8'd50; Op = 2'b00;
        #1;
        chk("display_live_b", 32'(disp_s), 32'd50);
        press();
        chk("add_state_show", 32'(st_s), 32'd4);
        chk("add_sat_result", 32'(res_s), 32'h7F);
        chk("add_sat_ovr", 32'(ovr_s), 32'd1);
        chk("add_cnt", 32'(cnt_s), 32'd1);
        chk("add_show_display", 32'({show_s, disp_s}), 32'h17F);
        chk("add_wrap_result", 32'(res_w), 32'h96);
        chk("add_wrap_ovr", 32'(ovr_w), 32'd1);

        // restart clears OpCount and OVR
        Chain = 1'b0;
        press();
        chk("restart_state", 32'(st_s), 32'd1);
        chk("restart_cnt_ovr", 32'({cnt_s, ovr_s}), 32'd0);

        // -128 - 1
        Operand = 8'h80;
        press();
        Operand = 8'h01; Op = 2'b01;
        press();
        chk("sub_wrap_result", 32'(res_w), 32'h7F);
        chk("sub_wrap_ovr", 32'(ovr_w), 32'd1);
        chk("sub_sat_result", 32'(res_s), 32'h80);
        chk("sub_sat_ovr", 32'(ovr_s), 32'd1);

        // chain: 5 + 3 = 8, then 8 - (-10) = 18
        press();
        Operand = 8'd5;
        press();
        Operand = 8'd3; Op = 2'b00;
        press();
        chk("chain_first_result", 32'(res_s), 32'd8);
        chk("chain_first_ovr", 32'(ovr_s), 32'd0);
        Chain = 1'b1;
        press();
        chk("chain_to_get_b", 32'(st_s), 32'd2);
        Chain = 1'b0;
        Operand = 8'hF6; Op = 2'b01;
        press();
        chk("chain_result", 32'(res_s), 32'd18);
        chk("chain_result_wrap", 32'(res_w), 32'd18);
        chk("chain_cnt", 32'(cnt_s), 32'd2);
        press();
        chk("chain_end_state", 32'(st_s), 32'd1);
        chk("chain_end_cnt_ovr", 32'({cnt_s, ovr_s}), 32'd0);

        // error path
        Operand = 8'd7;
        press();
        OperandValid = 1'b0;
        press();
        chk("err_state", 32'(st_s), 32'd5);
        chk("err_flag", 32'(err_s), 32'd1);
        chk("err_display", 32'(disp_s), 32'd0);
        chk("err_result_cleared", 32'(res_s), 32'd0);
        OperandValid = 1'b1;
        press();
        chk("err_exit_state", 32'(st_s), 32'd1);
        chk("err_exit_flag", 32'(err_s), 32'd0);

        // max / min of -3 and 7
        Operand = 8'hFD;
        press();
        Operand = 8'd7; Op = 2'b10;
        press();
        chk("max_result", 32'(res_s), 32'd7);
        chk("max_ovr", 32'(ovr_s), 32'd0);
        press();
        Operand = 8'hFD;
        press();
        Operand = 8'd7; Op = 2'b11;
        press();
        chk("min_result", 32'(res_s), 32'hFD);
        chk("min_ovr", 32'(ovr_s), 32'd0);
        chk("min_cnt", 32'(cnt_s), 32'd1);

        // reset asserted in EXEC
        Chain = 1'b1;
        press();
        Chain = 1'b0;
        Operand = 8'd20; Op = 2'b00;
        Enter = 1'b1;
        tick();
        chk("exec_state", 32'(st_s), 32'd3);
        Reset = 1'b1; Enter = 1'b0;
        tick();
        chk("rst_exec_state", 32'(st_s), 32'd0);
        chk("rst_exec_result", 32'(res_s), 32'd0);
        chk("rst_exec_cnt_ovr", 32'({cnt_s, ovr_s}), 32'd0);
        Reset = 1'b0;
        tick();

        // OpCount saturates at 15: 1+1 then 15 chained +1 gives 17
        press();
        Operand = 8'd1;
        press();
        Op = 2'b00;
        press();
        Chain = 1'b1;
        for (int i = 0; i < 15; i++) begin
            press();
            press();
        end
        chk("cnt_saturate", 32'(cnt_s), 32'd15);
        chk("cnt_chain_result", 32'(res_s), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
